// File: rtl/turn_lane_queue_ctrl_pkg.sv
// Shared types and helpers for the turn-lane queue controller and its
// saturating car counter.
package turn_lane_queue_ctrl_pkg;

  typedef enum logic [1:0] {
    TQ_IDLE    = 2'd0,
    TQ_REQUEST = 2'd1,
    TQ_HOLDOFF = 2'd2
  } turn_q_state_t;

  function automatic int cnt_width(input int max_cars);
    return $clog2(max_cars + 1);
  endfunction

endpackage

// File: rtl/turn_lane_queue_ctrl_if.sv
// Lane-side bus: arrival/arrow/ack inputs and the request, count and status
// outputs toward the animator and the VGA lane renderer.
interface turn_lane_queue_ctrl_if #(
  parameter int MAX_CARS = 8,
  parameter int CNT_W    = $clog2(MAX_CARS + 1)
);
  logic                car_arrive;
  logic                turn_green;
  logic                decrement_car;
  logic                add_car;
  logic [CNT_W-1:0]    car_count;
  logic [MAX_CARS-1:0] queue_display;
  logic                queue_full;
  logic                queue_empty;
  logic                drop_pulse;
  logic                ack_timeout;

  modport master (
    output car_arrive, turn_green, decrement_car,
    input  add_car, car_count, queue_display, queue_full, queue_empty,
           drop_pulse, ack_timeout
  );

  modport slave (
    input  car_arrive, turn_green, decrement_car,
    output add_car, car_count, queue_display, queue_full, queue_empty,
           drop_pulse, ack_timeout
  );
endinterface

// File: rtl/turn_lane_queue_ctrl_sat_car_counter.sv
// Up/down car counter saturating at 0 and MAX; shared by the lane queue
// controllers.
module sat_car_counter #(
  parameter int MAX   = 8,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_reject
);
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_dec_ok;
  logic             w_inc_ok;

  assign w_full   = (r_count == CNT_W'(MAX));
  assign w_empty  = (r_count == '0);
  assign w_dec_ok = i_dec && !w_empty;
  // A departure in the same cycle frees the slot an arrival needs when full.
  assign w_inc_ok = i_inc && (!w_full || w_dec_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_inc_ok && !w_dec_ok) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_dec_ok && !w_inc_ok) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_reject = i_inc && !w_inc_ok;
endmodule

// File: rtl/turn_lane_queue_ctrl.sv
// Left-turn lane queue: counts waiting cars, requests the animator one car at
// a time while the arrow is green, and drives the thermometer lane image.
module turn_lane_queue_ctrl
  import turn_lane_queue_ctrl_pkg::*;
#(
  parameter int MAX_CARS    = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  traffic_clk,
  input  logic                  reset,
  turn_lane_queue_ctrl_if.slave q_if
);
  localparam int CNT_W  = cnt_width(MAX_CARS);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  turn_q_state_t       r_state;
  logic                r_add_car;
  logic                r_timeout;
  logic                r_drop;
  logic [WAIT_W-1:0]   r_wait;
  logic [GAP_W-1:0]    r_gap;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_reject;
  logic [MAX_CARS-1:0] w_display;

  sat_car_counter #(.MAX(MAX_CARS), .CNT_W(CNT_W)) u_counter (
    .clk      (traffic_clk),
    .rst      (reset),
    .i_inc    (q_if.car_arrive),
    .i_dec    (q_if.decrement_car),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_reject (w_reject)
  );

  // add_car is registered alongside the state so it is exactly (state == REQUEST).
  always_ff @(posedge traffic_clk) begin
    if (reset) begin
      r_state   <= TQ_IDLE;
      r_add_car <= 1'b0;
      r_timeout <= 1'b0;
      r_drop    <= 1'b0;
      r_wait    <= '0;
      r_gap     <= '0;
    end else begin
      r_timeout <= 1'b0;
      r_drop    <= w_reject;
      case (r_state)
        TQ_IDLE: begin
          if (q_if.turn_green && !w_empty) begin
            r_state   <= TQ_REQUEST;
            r_add_car <= 1'b1;
            r_wait    <= '0;
          end
        end
        TQ_REQUEST: begin
          if (q_if.decrement_car) begin
            r_state   <= TQ_HOLDOFF;
            r_add_car <= 1'b0;
            r_gap     <= '0;
          end else if (!q_if.turn_green) begin
            r_state   <= TQ_IDLE;
            r_add_car <= 1'b0;
          end else if (r_wait == WAIT_W'(ACK_TIMEOUT - 1)) begin
            r_state   <= TQ_IDLE;
            r_add_car <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        TQ_HOLDOFF: begin
          if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= TQ_IDLE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: begin
          r_state   <= TQ_IDLE;
          r_add_car <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_display = '0;
    for (int i = 0; i < MAX_CARS; i++) begin
      w_display[i] = (w_count > CNT_W'(i));
    end
  end

  assign q_if.add_car       = r_add_car;
  assign q_if.car_count     = w_count;
  assign q_if.queue_display = w_display;
  assign q_if.queue_full    = w_full;
  assign q_if.queue_empty   = w_empty;
  assign q_if.drop_pulse    = r_drop;
  assign q_if.ack_timeout   = r_timeout;
endmodule
